// File: rtl/gig_mac_rx_ring_ctrl_if.sv
// Handshake bundle between the RX ring controller, the MAC RX DMA
// (allocation side) and the CSR/host side (consumption side).
interface gig_mac_rx_ring_ctrl_if #(
  parameter int AXI_WIDTH_AD = 32
) ();
  logic                    conf_en;
  logic                    alloc_req;
  logic [15:0]             alloc_len;
  logic                    alloc_gnt;
  logic                    alloc_drop;
  logic [AXI_WIDTH_AD-1:0] alloc_addr;
  logic                    wr_done;
  logic                    wr_abort;
  logic                    rd_valid;
  logic [AXI_WIDTH_AD-1:0] rd_addr;
  logic [15:0]             rd_len;
  logic                    rd_ack;
  logic                    irq_en;
  logic                    irq_clr;
  logic                    irq;
  logic [15:0]             rooms;
  logic [15:0]             items;
  logic [15:0]             drop_cnt;

  // DMA/host side: drives requests, observes ring status.
  modport master (
    output conf_en, alloc_req, alloc_len, wr_done, wr_abort, rd_ack, irq_en, irq_clr,
    input  alloc_gnt, alloc_drop, alloc_addr, rd_valid, rd_addr, rd_len, irq,
           rooms, items, drop_cnt
  );

  // Ring controller side.
  modport slave (
    input  conf_en, alloc_req, alloc_len, wr_done, wr_abort, rd_ack, irq_en, irq_clr,
    output alloc_gnt, alloc_drop, alloc_addr, rd_valid, rd_addr, rd_len, irq,
           rooms, items, drop_cnt
  );
endinterface

// File: rtl/gig_mac_rx_ring_ctrl.sv
// RX frame-buffer ring controller: reserves ring space per incoming frame,
// commits or releases it, presents committed frames in arrival order and
// raises a coalesced (count or timeout) interrupt. Addresses only, no data.
module gig_mac_rx_ring_ctrl #(
  parameter int                      AXI_WIDTH_AD = 32,
  parameter logic [AXI_WIDTH_AD-1:0] RING_START   = 32'h1000_0100,
  parameter int                      RING_SIZE    = 2048,
  parameter int                      DEPTH_FRAMES = 16,
  parameter int                      IRQ_COUNT    = 4,
  parameter int                      IRQ_TIMEOUT  = 1000
) (
  input  logic                   ACLK,
  input  logic                   ARESETn,
  gig_mac_rx_ring_ctrl_if.slave  bus
);

  localparam int OW = $clog2(RING_SIZE);
  localparam int PW = $clog2(DEPTH_FRAMES);
  localparam int TW = $clog2(IRQ_TIMEOUT + 1);

  localparam logic [15:0]   ROOM_FULL = 16'(RING_SIZE);
  localparam logic [15:0]   MAX_LEN   = 16'(RING_SIZE - 4);
  localparam logic [15:0]   FIFO_CAP  = 16'(DEPTH_FRAMES);
  localparam logic [15:0]   IRQ_THR   = 16'(IRQ_COUNT);
  localparam logic [TW-1:0] TMO_LAST  = TW'(IRQ_TIMEOUT - 1);

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  state_e                  state_q, state_d;
  logic [OW-1:0]           head_q, head_d, tail_q, tail_d;
  logic [15:0]             rooms_q, rooms_d, items_q, items_d, drop_q, drop_d;
  logic [15:0]             len_q, len_d, need_q, need_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic                    gnt_q, gnt_d, refuse_q, refuse_d;
  logic [AXI_WIDTH_AD-1:0] alloc_addr_q, alloc_addr_d, rd_addr_q, rd_addr_d;
  logic [15:0]             rd_len_q, rd_len_d;
  logic                    rd_valid_q, rd_valid_d;
  logic                    irq_q, irq_d;
  logic [TW-1:0]           timer_q, timer_d;

  // Only lengths are stored: committed slots are contiguous, so the head
  // offset is always recoverable by stepping over the popped slot.
  logic [15:0] fifo_len [DEPTH_FRAMES];

  logic        push, pop, grant, abort, irq_cond;
  logic [17:0] req_need;
  logic [15:0] pop_need;

  // Slot footprint: 4-byte header plus payload rounded up to a word.
  function automatic logic [17:0] need_of(input logic [15:0] len);
    logic [17:0] rounded;
    rounded = ({2'b00, len} + 18'd3) & ~18'd3;
    return rounded + 18'd4;
  endfunction

  // Next-state logic for allocation FSM, ring pointers, FIFO and interrupt.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned; otherwise synthesis would infer a latch to hold it.
    state_d      = state_q;
    head_d       = head_q;
    tail_d       = tail_q;
    rooms_d      = rooms_q;
    items_d      = items_q;
    drop_d       = drop_q;
    len_d        = len_q;
    need_d       = need_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    alloc_addr_d = alloc_addr_q;
    gnt_d        = 1'b0;
    refuse_d     = 1'b0;
    push         = 1'b0;
    grant        = 1'b0;
    abort        = 1'b0;
    timer_d      = timer_q;
    irq_d        = irq_q;

    req_need = need_of(bus.alloc_len);
    // Head frames are at most RING_SIZE-4 long, so this cannot overflow.
    pop_need = ((rd_len_q + 16'd3) & ~16'd3) + 16'd4;
    pop      = bus.rd_ack && (items_q != 16'd0);

    case (state_q)
      S_IDLE: begin
        if (bus.alloc_req) begin
          if (bus.conf_en && (bus.alloc_len != 16'd0) && (bus.alloc_len <= MAX_LEN) &&
              (req_need <= {2'b00, rooms_q}) && (items_q < FIFO_CAP)) begin
            grant        = 1'b1;
            gnt_d        = 1'b1;
            alloc_addr_d = RING_START + AXI_WIDTH_AD'(tail_q);
            len_d        = bus.alloc_len;
            need_d       = req_need[15:0];
            state_d      = S_BUSY;
          end else begin
            refuse_d = 1'b1;
            drop_d   = (drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1;
          end
        end
      end
      S_BUSY: begin
        // Commit has priority over abort when both arrive together.
        if (bus.wr_done) begin
          push     = 1'b1;
          tail_d   = tail_q + need_q[OW-1:0];
          wr_ptr_d = wr_ptr_q + 1'b1;
          state_d  = S_IDLE;
        end else if (bus.wr_abort) begin
          abort   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (pop) begin
      head_d   = head_q + pop_need[OW-1:0];
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // Reservation, release and consumption may all land in one cycle.
    rooms_d = rooms_q - (grant ? req_need[15:0] : 16'd0)
                      + (abort ? need_q : 16'd0)
                      + (pop ? pop_need : 16'd0);

    case ({push, pop})
      2'b10:   items_d = items_q + 16'd1;
      2'b01:   items_d = items_q - 16'd1;
      default: items_d = items_q;
    endcase

    // Head frame as seen after this edge; it may be the entry being pushed.
    rd_valid_d = (items_d != 16'd0);
    rd_addr_d  = RING_START + AXI_WIDTH_AD'(head_d);
    if (items_d == 16'd0)
      rd_len_d = 16'd0;
    else if (push && (rd_ptr_d == wr_ptr_q))
      rd_len_d = len_q;
    else
      rd_len_d = fifo_len[rd_ptr_d];

    irq_cond = bus.irq_en && ((items_q >= IRQ_THR) ||
                              ((timer_q == TMO_LAST) && (items_q != 16'd0)));
    if (!bus.irq_en || bus.irq_clr)
      irq_d = 1'b0;
    else if (irq_cond)
      irq_d = 1'b1;

    if (!bus.irq_en || (items_q == 16'd0) || irq_q || bus.irq_clr || irq_cond)
      timer_d = '0;
    else
      timer_d = timer_q + 1'b1;
  end

  // State and output registers; reset discards any outstanding reservation.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!ARESETn) begin
      state_q      <= S_IDLE;
      head_q       <= '0;
      tail_q       <= '0;
      rooms_q      <= ROOM_FULL;
      items_q      <= '0;
      drop_q       <= '0;
      len_q        <= '0;
      need_q       <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      gnt_q        <= 1'b0;
      refuse_q     <= 1'b0;
      alloc_addr_q <= RING_START;
      rd_addr_q    <= RING_START;
      rd_len_q     <= '0;
      rd_valid_q   <= 1'b0;
      irq_q        <= 1'b0;
      timer_q      <= '0;
    end else begin
      state_q      <= state_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      rooms_q      <= rooms_d;
      items_q      <= items_d;
      drop_q       <= drop_d;
      len_q        <= len_d;
      need_q       <= need_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      gnt_q        <= gnt_d;
      refuse_q     <= refuse_d;
      alloc_addr_q <= alloc_addr_d;
      rd_addr_q    <= rd_addr_d;
      rd_len_q     <= rd_len_d;
      rd_valid_q   <= rd_valid_d;
      irq_q        <= irq_d;
      timer_q      <= timer_d;
    end
  end

  // Frame-length FIFO storage, written on commit.
  always_ff @(posedge ACLK) begin
    // NOTE: the storage array has no reset; validity is tracked by the
    // reset pointers and count, so clearing the contents would buy nothing.
    if (push) fifo_len[wr_ptr_q] <= len_q;
  end

  assign bus.alloc_gnt  = gnt_q;
  assign bus.alloc_drop = refuse_q;
  assign bus.alloc_addr = alloc_addr_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.rd_addr    = rd_addr_q;
  assign bus.rd_len     = rd_len_q;
  assign bus.irq        = irq_q;
  assign bus.rooms      = rooms_q;
  assign bus.items      = items_q;
  assign bus.drop_cnt   = drop_q;

endmodule
